// File: rtl/seq_nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and slice geometry.
// The slice-index width helper keeps the top and any wrapper in agreement.
package seq_nibble_add_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One extra bit so the index can reach NIBBLES without wrapping.
  function automatic int idx_width(input int nibbles);
    return $clog2(nibbles) + 1;
  endfunction

endpackage

// File: rtl/seq_nibble_add_par_4bit_add.sv
// Combinational 4-bit ripple adder used as the single slice of the serial datapath.
// Exposes the carry into the MSB so the top can form signed overflow on the last slice.
module par_4bit_add
  import seq_nibble_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               c_msb
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < SLICE_W; gi++) begin : g_bit
      assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout  = c[SLICE_W];
  assign c_msb = c[SLICE_W-1];

endmodule

// File: rtl/seq_nibble_add.sv
// Nibble-serial adder/subtractor: one 4-bit slice per cycle, LS slice first,
// with a valid/ready handshake on both the operand and the result side.
module seq_nibble_add
  import seq_nibble_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SLICE_W*NIBBLES-1:0] a,
  input  logic [SLICE_W*NIBBLES-1:0] b,
  input  logic                       cin,
  input  logic                       sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SLICE_W*NIBBLES-1:0] sum,
  output logic                       cout,
  output logic                       ovf
);

  localparam int W     = SLICE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t            state_reg, state_next;
  logic [W-1:0]      a_reg, b_reg;
  logic [W-1:0]      sum_reg, sum_next;
  logic              carry_reg;
  logic              cout_reg, ovf_reg;
  logic [IDX_W-1:0]  idx_reg;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               slice_cmsb;
  logic               accept;
  logic               running;
  logic               last_slice;

  assign accept     = (state_reg == ST_IDLE) && in_valid;
  assign running    = (state_reg == ST_RUN);
  assign last_slice = running && (idx_reg == LAST_IDX);

  // Operands shift right each RUN cycle, so the slice adder always sees bits [3:0].
  par_4bit_add u_slice (
    .a     (a_reg[SLICE_W-1:0]),
    .b     (b_reg[SLICE_W-1:0]),
    .cin   (carry_reg),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (in_valid)   state_next = ST_RUN;
      ST_RUN:  if (last_slice) state_next = ST_DONE;
      ST_DONE: if (out_ready)  state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Each result nibble is written in place when its slice index comes up.
  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_sum_wr
      assign sum_next[gi*SLICE_W +: SLICE_W] =
        (running && (idx_reg == IDX_W'(gi))) ? slice_sum
                                             : sum_reg[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx_reg   <= '0;
    end else begin
      sum_reg <= sum_next;
      if (accept) begin
        // Subtraction is A + ~B + 1; cin only matters in add mode.
        a_reg     <= a;
        b_reg     <= sub ? ~b : b;
        carry_reg <= sub ? 1'b1 : cin;
        idx_reg   <= '0;
      end else if (running) begin
        a_reg     <= a_reg >> SLICE_W;
        b_reg     <= b_reg >> SLICE_W;
        carry_reg <= slice_cout;
        idx_reg   <= idx_reg + IDX_W'(1);
        if (last_slice) begin
          cout_reg <= slice_cout;
          ovf_reg  <= slice_cout ^ slice_cmsb;
        end
      end
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_seq_nibble_add.sv
// Directed bench for seq_nibble_add: expected results are queued at operand
// acceptance and compared when the DUT presents them.
module tb_seq_nibble_add;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  seq_nibble_add #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input logic sv);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb     = sv ? ~bv : bv;
    full   = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, (sv ? 1'b1 : cv)};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (av[W-1] == bb[W-1]) && (full[W-1] != av[W-1]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input logic sv);
    @(posedge clk); #1;
    in_valid = 1'b1;
    a = av; b = bv; cin = cv; sub = sv;
  endtask

  // Waits for in_ready, lets the next edge take the operands and queues the expectation.
  task automatic accept_one(input bit keep, output int waited);
    int t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", in_ready, 1);
    waited = t;
    @(posedge clk);
    sb.push_back(model(a, b, cin, sub));
    $display("accept a=%h b=%h cin=%0b sub=%0b", a, b, cin, sub);
    #1;
    if (!keep) begin
      in_valid = 1'b0;
      a   = W'($urandom);
      b   = W'($urandom);
      sub = ~sub;
    end
  endtask

  task automatic wait_result(input int hold);
    int           edges = 1;
    exp_t         e;
    logic [W-1:0] s0;
    logic         c0, o0;
    @(negedge clk);
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("latency", edges, NIBBLES + 1);
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      $display("result sum=%h cout=%0b ovf=%0b (want %h %0b %0b)", sum, cout, ovf,
               e.sum, e.cout, e.ovf);
      check("sum", sum, e.sum);
      check("cout", cout, e.cout);
      check("ovf", ovf, e.ovf);
    end
    s0 = sum; c0 = cout; o0 = ovf;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_sum", sum, s0);
      check("hold_cout", cout, c0);
      check("hold_ovf", ovf, o0);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("post_take_valid", out_valid, 0);
    check("post_take_ready", in_ready, 1);
  endtask

  initial begin
    int waited;
    int seen;
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0;

    // Reset, with in_valid asserted throughout.
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);

    drive(16'h1234, 16'h4321, 1'b0, 1'b0); accept_one(0, waited); wait_result(0);
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0); accept_one(0, waited); wait_result(0);
    drive(16'h0005, 16'h0007, 1'b1, 1'b1); accept_one(0, waited); wait_result(0);
    drive(16'h8000, 16'h0001, 1'b0, 1'b1); accept_one(0, waited); wait_result(0);
    drive(16'h0FFF, 16'h0000, 1'b1, 1'b0); accept_one(0, waited); wait_result(0);

    // Stall in DONE while a new request waits; it must be taken only after the result.
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0); accept_one(0, waited);
    in_valid = 1'b1; a = 16'h00A0; b = 16'h0B00; cin = 1'b0; sub = 1'b0;
    wait_result(3);
    accept_one(0, waited);
    check("stall_reaccept_gap", waited, 0);
    wait_result(0);

    // Back-to-back with in_valid held; operands changed mid-run must not disturb the first.
    drive(16'h1234, 16'h1111, 1'b0, 1'b1); accept_one(1, waited);
    a = 16'hABCD; b = 16'h0123; cin = 1'b1; sub = 1'b0;
    wait_result(0);
    accept_one(0, waited);
    check("b2b_gap", waited, 0);
    wait_result(0);

    // Reset in the second RUN cycle aborts the transaction.
    drive(16'h1111, 16'h2222, 1'b0, 1'b0); accept_one(0, waited);
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_ovf", ovf, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_output", seen, 0);
    check("abort_idle", in_ready, 1);
    drive(16'h0001, 16'h0001, 1'b0, 1'b0); accept_one(0, waited); wait_result(0);

    for (int i = 0; i < 4; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      accept_one(0, waited);
      wait_result(i % 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
